// File: rtl/pwm_ramp_sequencer.sv
// Walks the PWM duty-cycle value toward a host-supplied target, one saturating
// step per programmable interval, and pulses done when the target is reached.
module pwm_ramp_sequencer #(
    parameter int DW = 8,
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_target,
    input  logic [DW-1:0] cfg_step,
    input  logic [IW-1:0] cfg_interval,
    input  logic          abort,
    output logic [DW-1:0] duty_out,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_STEP = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t        state_reg,    state_next;
    logic [DW-1:0] duty_reg,     duty_next;
    logic [DW-1:0] target_reg,   target_next;
    logic [DW-1:0] step_reg,     step_next;
    logic [IW-1:0] interval_reg, interval_next;
    logic [IW-1:0] cnt_reg,      cnt_next;

    // One extra bit so the up/down comparisons never see a wrapped value.
    logic [DW:0]   sum_wide;
    logic [DW:0]   diff_wide;
    logic [DW-1:0] step_val;

    always_comb begin
        sum_wide  = {1'b0, duty_reg} + {1'b0, step_reg};
        diff_wide = {1'b0, duty_reg} - {1'b0, target_reg};
        if (target_reg > duty_reg) begin
            step_val = (sum_wide >= {1'b0, target_reg}) ? target_reg : sum_wide[DW-1:0];
        end else begin
            step_val = (diff_wide <= {1'b0, step_reg}) ? target_reg : duty_reg - step_reg;
        end
    end

    always_comb begin
        state_next    = state_reg;
        duty_next     = duty_reg;
        target_next   = target_reg;
        step_next     = step_reg;
        interval_next = interval_reg;
        cnt_next      = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cfg_valid && !abort) begin
                    target_next   = cfg_target;
                    step_next     = (cfg_step == '0) ? DW'(1) : cfg_step;
                    interval_next = cfg_interval;
                    cnt_next      = cfg_interval;
                    state_next    = (cfg_target == duty_reg) ? ST_FIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = ST_STEP;
                end else begin
                    cnt_next = cnt_reg - IW'(1);
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    duty_next  = step_val;
                    cnt_next   = interval_reg;
                    state_next = (step_val == target_reg) ? ST_FIN : ST_WAIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            duty_reg     <= '0;
            target_reg   <= '0;
            step_reg     <= DW'(1);
            interval_reg <= '0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            duty_reg     <= duty_next;
            target_reg   <= target_next;
            step_reg     <= step_next;
            interval_reg <= interval_next;
            cnt_reg      <= cnt_next;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free.
    assign duty_out  = duty_reg;
    assign cfg_ready = (state_reg == ST_IDLE);
    assign busy      = (state_reg == ST_WAIT) || (state_reg == ST_STEP);
    assign done      = (state_reg == ST_FIN);

endmodule
